// File: rtl/micro_sequencer.sv
// micro_sequencer: registered micro-address generator for a microcoded
// control unit. One micro-step per clock: addr_ins is updated on posedge clk
// and sampled by the control unit on the following negedge.
//
// Optional feature: define SEQ_TIMEOUT_EN to enable the memory-wait
// watchdog (wait counter + sticky mem_timeout). When undefined, there is no
// counter logic, mem_timeout is tied low and memory waits are unbounded.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | advancing one micro-step per cycle from ctrl_word
// HOLD  | en low; micro-address (and wait counter) frozen
// HALT  | addr_ins parked at 0x0FF; left only through reset
module micro_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [38:0] ctrl_word,
  input  logic [4:0]  ir_opcode,
  input  logic        hit,
  input  logic        z_flag,
  output logic [8:0]  addr_ins,
  output logic        halted,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [8:0] ADDR_FETCH1 = 9'h000;
  localparam logic [8:0] ADDR_HALT   = 9'h0FF;
  localparam logic [4:0] OP_HALT     = 5'b11111;
  localparam logic [7:0] TO_LIM      = 8'(TIMEOUT_CYCLES);

  state_t     state_q, state_d;
  logic [8:0] addr_q, addr_d;

  logic [4:0] next_op;
  logic [2:0] next_step;
  logic [2:0] cond;
  logic [2:0] mem_req;
  logic       mem_wait;

  assign next_op   = ctrl_word[38:34];
  assign next_step = ctrl_word[33:31];
  assign cond      = ctrl_word[30:28];
  assign mem_req   = ctrl_word[2:0];
  // A pending request that memory has not yet answered.
  assign mem_wait  = (mem_req != 3'b000) && !hit;

  // Bits of the control word this block does not consume (cond[1] is
  // deliberately ignored).
  logic unused_bits;
  assign unused_bits = ^{ctrl_word[27:3], cond[1], TO_LIM};

  // Branch selection for an advancing cycle:
  // halt > decode > Z-branch > hit-qualify > sequential.
  logic       halt_req;
  logic [8:0] sel_addr;
  always_comb begin
    halt_req = 1'b0;
    sel_addr = {1'b0, next_op, next_step};
    if (next_op == OP_HALT) begin
      halt_req = 1'b1;
    end else if (cond[2]) begin
      if (ir_opcode == OP_HALT) begin
        halt_req = 1'b1;
      end else begin
        sel_addr = {1'b0, ir_opcode, 3'b000};
      end
    end else if (cond[0]) begin
      sel_addr = {z_flag, next_op, next_step};
    end else if (mem_req != 3'b000) begin
      sel_addr = {hit, next_op, next_step};
    end
  end

  logic advance;
  assign advance = en && (state_q != ST_HALT);

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       timeout_fire;

  // Watchdog: count consecutive unanswered wait cycles while advancing;
  // reaching the limit latches mem_timeout and forces HALT.
  always_comb begin
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    timeout_fire = 1'b0;
    if (advance) begin
      if (mem_wait) begin
        wait_d = wait_q + 8'd1;
        if (wait_d == TO_LIM) begin
          timeout_fire = 1'b1;
          timeout_d    = 1'b1;
        end
      end else begin
        wait_d = 8'd0;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
`else
  logic timeout_fire;
  logic unused_wait;
  assign timeout_fire = 1'b0;
  assign unused_wait  = mem_wait;
  assign mem_timeout  = 1'b0;
`endif

  // Next-state / next-address logic; HALT and HOLD keep the address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (!en) begin
          state_d = ST_HOLD;
        end else if (halt_req || timeout_fire) begin
          state_d = ST_HALT;
          addr_d  = ADDR_HALT;
        end else begin
          state_d = ST_RUN;
          addr_d  = sel_addr;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        addr_d  = ADDR_HALT;
      end
      default: begin
        state_d = ST_RUN;
        addr_d  = ADDR_FETCH1;
      end
    endcase
  end

  // State and micro-address registers; reset parks at FETCH1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      addr_q  <= ADDR_FETCH1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign addr_ins = addr_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the stimulus thread pushes the
// hand-computed expected outputs; a monitor pops and compares one entry
// after every posedge and after every asynchronous reset assertion.
module tb_micro_sequencer;

  logic        clk;
  logic        reset;
  logic        en;
  logic [38:0] ctrl_word;
  logic [4:0]  ir_opcode;
  logic        hit;
  logic        z_flag;
  logic [8:0]  addr_ins;
  logic        halted;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] addr;
    logic       halted;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  micro_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ctrl_word  (ctrl_word),
    .ir_opcode  (ir_opcode),
    .hit        (hit),
    .z_flag     (z_flag),
    .addr_ins   (addr_ins),
    .halted     (halted),
    .mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ignored middle bits set to ones so they must not matter.
  function automatic logic [38:0] cw(input logic [4:0] op, input logic [2:0] st,
                                     input logic [2:0] cnd, input logic [2:0] mem);
    logic [38:0] w;
    w        = '1;
    w[38:34] = op;
    w[33:31] = st;
    w[30:28] = cnd;
    w[2:0]   = mem;
    return w;
  endfunction

  task automatic push_exp(input string name, input logic [8:0] a, input logic h, input logic t);
    exp_t e;
    e.addr   = a;
    e.halted = h;
    e.to     = t;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs at negedge and queue the result due after the
  // next posedge.
  task automatic step(input string name, input logic e, input logic [38:0] w,
                      input logic [4:0] ir, input logic h_in, input logic z,
                      input logic [8:0] a, input logic h, input logic t);
    @(negedge clk);
    en        = e;
    ctrl_word = w;
    ir_opcode = ir;
    hit       = h_in;
    z_flag    = z;
    push_exp(name, a, h, t);
  endtask

  // Assert reset mid-cycle (expect immediate FETCH1), then release with
  // en low so the release cycle does not advance.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    en = 1'b0;
    push_exp(name, 9'h000, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compare outputs after each posedge and each reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (addr_ins !== e.addr || halted !== e.halted || mem_timeout !== e.to) begin
          errors++;
          $display("FAIL %s: got addr_ins=%h halted=%b mem_timeout=%b, expected addr_ins=%h halted=%b mem_timeout=%b",
                   e.name, addr_ins, halted, mem_timeout, e.addr, e.halted, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    ctrl_word = '0;
    ir_opcode = '0;
    hit       = 1'b0;
    z_flag    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held with active inputs: stays at FETCH1.
    step("reset_hold", 1, cw(5'h1f, 3'd0, 3'b100, 3'b001), 5'h1f, 1, 1, 9'h000, 0, 0);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;

    // Memory wait loop then hit.
    step("wait1", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 0, 0, 9'h002, 0, 0);
    step("wait2", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 0, 0, 9'h002, 0, 0);
    step("wait3", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 0, 0, 9'h002, 0, 0);
    step("wait_hit", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 1, 0, 9'h102, 0, 0);

    // cond[1] ignored -> sequential.
    step("cond1_ignored", 1, cw(5'h03, 3'd5, 3'b010, 3'b000), 5'h00, 1, 1, 9'h01D, 0, 0);
    // Hit-qualify.
    step("hitq_hit", 1, cw(5'h05, 3'd3, 3'b000, 3'b100), 5'h00, 1, 0, 9'h12B, 0, 0);
    step("hitq_miss", 1, cw(5'h05, 3'd3, 3'b000, 3'b100), 5'h00, 0, 1, 9'h02B, 0, 0);
    // Z-branch.
    step("zbr_z1", 1, cw(5'h16, 3'd1, 3'b001, 3'b000), 5'h00, 0, 1, 9'h1B1, 0, 0);
    step("zbr_z0", 1, cw(5'h16, 3'd1, 3'b001, 3'b000), 5'h00, 0, 0, 9'h0B1, 0, 0);
    step("zbr_over_hit", 1, cw(5'h16, 3'd1, 3'b001, 3'b001), 5'h00, 1, 0, 9'h0B1, 0, 0);
    step("zbr_over_miss", 1, cw(5'h16, 3'd1, 3'b001, 3'b001), 5'h00, 0, 1, 9'h1B1, 0, 0);
    // Decode.
    step("decode", 1, cw(5'h07, 3'd7, 3'b100, 3'b000), 5'h0A, 0, 0, 9'h050, 0, 0);
    step("decode_over_z", 1, cw(5'h07, 3'd7, 3'b101, 3'b000), 5'h0A, 0, 1, 9'h050, 0, 0);
    step("decode_over_hit", 1, cw(5'h07, 3'd7, 3'b100, 3'b001), 5'h0A, 1, 0, 9'h050, 0, 0);

    // HOLD: four cycles of changing inputs, address frozen.
    step("hold1", 0, cw(5'h01, 3'd1, 3'b000, 3'b000), 5'h00, 0, 0, 9'h050, 0, 0);
    step("hold2", 0, cw(5'h1f, 3'd0, 3'b000, 3'b000), 5'h00, 1, 1, 9'h050, 0, 0);
    step("hold3", 0, cw(5'h02, 3'd2, 3'b100, 3'b000), 5'h1f, 0, 1, 9'h050, 0, 0);
    step("hold4", 0, cw(5'h16, 3'd1, 3'b001, 3'b010), 5'h00, 0, 1, 9'h050, 0, 0);
    step("resume", 1, cw(5'h0C, 3'd6, 3'b000, 3'b000), 5'h00, 0, 0, 9'h066, 0, 0);

    // Decode of the halt opcode, then HALT is sticky through en toggles.
    step("decode_halt", 1, cw(5'h00, 3'd1, 3'b100, 3'b000), 5'h1f, 0, 0, 9'h0FF, 1, 0);
    step("halt_en0", 0, cw(5'h02, 3'd2, 3'b000, 3'b000), 5'h00, 0, 0, 9'h0FF, 1, 0);
    step("halt_en1", 1, cw(5'h03, 3'd3, 3'b000, 3'b000), 5'h00, 1, 1, 9'h0FF, 1, 0);
    step("halt_decode", 1, cw(5'h00, 3'd0, 3'b100, 3'b000), 5'h0A, 0, 0, 9'h0FF, 1, 0);
    step("halt_en0b", 0, cw(5'h00, 3'd0, 3'b000, 3'b001), 5'h00, 0, 0, 9'h0FF, 1, 0);
    do_reset("reset_in_halt");

    // Reset mid-wait.
    step("midwait1", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 0, 0, 9'h002, 0, 0);
    step("midwait2", 1, cw(5'h00, 3'd2, 3'b000, 3'b001), 5'h00, 0, 0, 9'h002, 0, 0);
    do_reset("reset_mid_wait");
    step("post_reset", 1, cw(5'h09, 3'd4, 3'b000, 3'b000), 5'h00, 0, 0, 9'h04C, 0, 0);

    // Halt from the control word, and its priority over decode.
    step("ctrl_halt", 1, cw(5'h1f, 3'd3, 3'b000, 3'b000), 5'h00, 0, 0, 9'h0FF, 1, 0);
    do_reset("reset_after_ctrl_halt");
    step("halt_over_decode", 1, cw(5'h1f, 3'd3, 3'b100, 3'b000), 5'h0A, 0, 0, 9'h0FF, 1, 0);
    do_reset("reset_after_halt_over_decode");

`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 254; i++)
      step("to_wait", 1, cw(5'h00, 3'd4, 3'b000, 3'b010), 5'h00, 0, 0, 9'h004, 0, 0);
    step("to_fire", 1, cw(5'h00, 3'd4, 3'b000, 3'b010), 5'h00, 0, 0, 9'h0FF, 1, 1);
    step("to_sticky", 1, cw(5'h00, 3'd4, 3'b000, 3'b010), 5'h00, 1, 0, 9'h0FF, 1, 1);
    do_reset("reset_clears_timeout");
`else
    for (int i = 0; i < 300; i++)
      step("unbounded_wait", 1, cw(5'h00, 3'd4, 3'b000, 3'b010), 5'h00, 0, 0, 9'h004, 0, 0);
    step("unbounded_hit", 1, cw(5'h00, 3'd4, 3'b000, 3'b010), 5'h00, 1, 0, 9'h104, 0, 0);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max consecutive unanswered memory-wait cycles (used only with SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  advance enable; low holds current micro-address.
REQ-005 SHALL have port ctrl_word  input  39  control word from control unit: [38:34] next_op, [33:31] next_step, [30:28] cond, [2:0] mem_req.
REQ-006 SHALL have port ir_opcode  input  5  opcode field of current instruction register.
REQ-007 SHALL have port hit  input  1  memory/cache ready for the pending request.
REQ-008 SHALL have port z_flag  input  1  accumulator zero flag.
REQ-009 SHALL have port addr_ins  output  9  registered micro-address {qual, op[4:0], step[2:0]} to control unit.
REQ-010 SHALL have port halted  output  1  high while in HALT state.
REQ-011 SHALL have port mem_timeout  output  1  sticky watchdog flag (constant 0 when SEQ_TIMEOUT_EN undefined).

Function
REQ-012 SHALL update addr_ins once per posedge clk; control unit samples it on the following negedge, giving one micro-step per cycle.
REQ-013 SHALL implement states RUN, HOLD, HALT; RUN->HOLD when en=0, HOLD->RUN when en=1, any->HALT per REQ-015, HALT exits only via reset.
REQ-014 SHALL select next addr_ins in RUN with priority: halt > decode > Z-branch > hit-qualify > sequential.
REQ-015 Halt: ctrl_word[38:34]=11111, or decode with ir_opcode=11111 -> addr_ins=9'b011111111, state HALT, halted=1 next cycle.
REQ-016 Decode: cond[2]=1 -> addr_ins={1'b0, ir_opcode, 3'b000}.
REQ-017 Z-branch: cond[0]=1 -> addr_ins={z_flag, next_op, next_step}.
REQ-018 Hit-qualify: mem_req!=000 -> addr_ins={hit, next_op, next_step}; with hit=0 the microcode loops in its own wait word.
REQ-019 Sequential: otherwise addr_ins={1'b0, next_op, next_step}.
REQ-020 cond[1] SHALL be ignored; cond[2] and cond[0] both set -> decode wins.
REQ-021 HOLD SHALL keep addr_ins unchanged regardless of ctrl_word, hit, z_flag; wait counter also frozen.
REQ-022 HALT SHALL keep addr_ins=9'b011111111 regardless of en and all inputs.

Reset
REQ-023 reset low SHALL immediately force addr_ins=9'b000000000 (FETCH1), state RUN, halted=0, mem_timeout=0, wait counter=0.
REQ-024 Reset asserted mid-wait or in HALT SHALL abandon the operation with no residual state; first advance after deassertion follows the ctrl_word presented.

Configuration
REQ-025 Macro SEQ_TIMEOUT_EN defined: 8-bit wait counter increments each RUN cycle with mem_req!=000 and hit=0, clears on hit=1 or mem_req=000; reaching TIMEOUT_CYCLES sets mem_timeout and forces HALT next cycle.
REQ-026 Macro SEQ_TIMEOUT_EN undefined: no counter logic, mem_timeout tied 0, waits unbounded.

Verification
REQ-027 Reset released, ctrl_word next_op=00000/step=010/cond=000/mem=001, hit=0 for 3 cycles then 1 -> addr_ins 0x002,0x002,0x002 then 0x102.
REQ-028 cond=100, ir_opcode=01010 -> addr_ins=0x050 (ADD1) next cycle; ir_opcode=11111 -> addr_ins=0x0FF, halted=1, stays after en toggles.
REQ-029 next_op=10110, step=001, cond=001: z_flag=1 -> 0x1B1; z_flag=0 -> 0x0B1.
REQ-030 en=0 for 4 cycles with changing ctrl_word -> addr_ins frozen; en=1 -> resumes per ctrl_word.
REQ-031 SEQ_TIMEOUT_EN defined, mem_req=010, hit held 0 -> mem_timeout=1 after 255 wait cycles, addr_ins=0x0FF; reset clears both to 0/0x000.
REQ-032 reset low while halted or mid-wait -> addr_ins=0x000 within same cycle, halted=0.
